core_periph_bridge: RTL and testbench
=====================================

# core_periph_bridge

Converts the EX-stage peripheral access flagged by the hazard unit's `d_valid` into a single request/acknowledge transaction on the peripheral bus. It returns `d_ready` for exactly one cycle when the transaction finishes, which releases the pipeline stall. Load data and an error flag are returned in that same cycle. The block sits between the EX/MEM stage and the peripheral interconnect, directly downstream of the hazard unit.

## Interface
- `PERIPHERAL_BASE`, 64'h2000_0000: base of the peripheral window; it is subtracted to form the bus offset.
- `TIMEOUT_CYCLES`, 255: maximum number of `REQ` cycles without `p_ack` before an access is aborted. The legal range is 1..65535.
- `clock` in 1: single clock; everything is updated on the rising edge.
- `reset` in 1: synchronous, active-high.
- `d_valid` in 1: the peripheral access is valid (from the hazard unit).
- `addr` in 64: EX-stage effective address.
- `EX_mem_read` in 1: the access is a load.
- `EX_mem_write` in 1: the access is a store.
- `wdata` in 64: store data.
- `byte_en` in 8: store byte lanes.
- `d_ready` out 1: one-cycle completion pulse to the hazard unit.
- `rdata` out 64: load data; valid only while `d_ready`=1.
- `d_err` out 1: the access failed; valid only while `d_ready`=1.
- `p_req` out 1: bus request.
- `p_we` out 1: bus write enable.
- `p_addr` out 32: bus offset, equal to `(addr - PERIPHERAL_BASE)[31:0]`.
- `p_wdata` out 64: bus write data.
- `p_be` out 8: bus byte enables. All ones on a read.
- `p_ack` in 1: the peripheral completed the request.
- `p_rdata` in 64: peripheral read data; sampled only when `p_ack`=1.
- `p_err` in 1: peripheral error; sampled only when `p_ack`=1.

## Operation
- FSM states: `IDLE`, `REQ`, `DONE`. Reset puts the FSM in `IDLE`.
- `IDLE`
  - When `d_valid`=1, capture `p_we`, `p_addr`, `p_wdata` and `p_be`, clear the timeout counter, and go to `REQ`.
  - `p_we` is captured as `EX_mem_write`. If `EX_mem_write` and `EX_mem_read` are both 1, the write wins.
  - When `d_valid`=0, stay in `IDLE`.
- `REQ`
  - `p_req`=1, and all `p_*` outputs are held stable.
  - When `p_ack`=1:
    - on a read, latch `rdata` from `p_rdata`; on a write, set `rdata`=0;
    - latch `d_err` from `p_err`;
    - go to `DONE`.
  - All EX-side inputs are ignored in this state. A `d_valid` drop does not cancel the access.
- `DONE`
  - `d_ready`=1 for exactly this one cycle, then go to `IDLE`.
  - The pipeline advances on this edge. `IDLE` therefore never relaunches the completed access.
- `p_ack` is ignored in the `IDLE` and `DONE` states.
- Back-to-back accesses:
  - `DONE` is always followed by at least one `IDLE` cycle.
  - A `d_valid` seen in that `IDLE` cycle belongs to the next instruction and starts a new access.
- Offset arithmetic is a 64-bit subtraction truncated to 32 bits. Address bits above 32 of the offset are discarded without any check.

## Timing
- Values of every output during and after reset:
  - `d_ready`=0, `d_err`=0, `rdata`=0;
  - `p_req`=0, `p_we`=0, `p_addr`=0, `p_wdata`=0, `p_be`=0.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.
- Latency, with `d_valid` first high in cycle 0:
  - `p_req` is high from cycle 1.
  - If `p_ack` arrives in cycle k≥1, `d_ready` is high in cycle k+1.
  - The minimum stall is 2 cycles.
- A `reset` asserted in any state:
  - returns the FSM to `IDLE` on the next edge, with all outputs at their reset values;
  - abandons the in-flight bus request;
  - does not pulse `d_ready`.

## Configuration
- `PERIPH_TIMEOUT_EN` defined:
  - A 16-bit counter increments in every `REQ` cycle that has no `p_ack`.
  - When the counter reaches `TIMEOUT_CYCLES`, the FSM goes to `DONE` with `d_err`=1 and `rdata`=0, and `p_req` drops.
  - If `p_ack` arrives in the same cycle as the timeout, `p_ack` wins.
- `PERIPH_TIMEOUT_EN` undefined:
  - There is no counter, and `REQ` waits for `p_ack` indefinitely.
  - `d_err` reflects only `p_err`.

## Test plan
- **Read:** `addr`=64'h2000_0010, `EX_mem_read`=1, `d_valid`=1 held, `p_ack` in the first `REQ` cycle with `p_rdata`=64'hDEAD_BEEF.
  - `p_addr`=32'h10 and `p_be`=8'hFF.
  - `d_ready` pulses in cycle 2 with `rdata`=64'hDEAD_BEEF and `d_err`=0.
- **Write with slow peripheral:** `EX_mem_write`=1, `wdata`=64'h55, `byte_en`=8'h0F, `p_ack` after 5 `REQ` cycles.
  - `p_req` is held for 5 cycles with stable `p_we`=1, `p_wdata` and `p_be`.
  - `d_ready` pulses in cycle 6.
- **Back-to-back:** two consecutive load instructions.
  - Exactly two `p_req` transactions occur, separated by one `IDLE` cycle.
  - Exactly two `d_ready` pulses occur, and there is no duplicate request.
- **Error:** `p_ack`=1 with `p_err`=1.
  - `d_ready`=1 and `d_err`=1 in the same cycle.
  - `d_err` is back to 0 in the next access's `DONE` if that access is clean.
- **Timeout** (`PERIPH_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=4), `p_ack` never asserted.
  - `p_req` is high for 4 cycles.
  - `d_ready`=1, `d_err`=1 and `rdata`=0 in the following cycle.
- **Reset mid-REQ:** assert `reset` in the second `REQ` cycle.
  - The next cycle shows `IDLE`, `p_req`=0 and `d_ready`=0.
  - A late `p_ack` after reset is ignored.

Source files
------------

// File: rtl/core_periph_bridge_if.sv
// Peripheral-bus signal bundle between the bridge (master) and the
// interconnect (slave): request/ack handshake plus write/read data.
interface core_periph_bridge_if;
    logic        p_req;
    logic        p_we;
    logic [31:0] p_addr;
    logic [63:0] p_wdata;
    logic [7:0]  p_be;
    logic        p_ack;
    logic [63:0] p_rdata;
    logic        p_err;

    modport master (
        output p_req,
        output p_we,
        output p_addr,
        output p_wdata,
        output p_be,
        input  p_ack,
        input  p_rdata,
        input  p_err
    );

    modport slave (
        input  p_req,
        input  p_we,
        input  p_addr,
        input  p_wdata,
        input  p_be,
        output p_ack,
        output p_rdata,
        output p_err
    );
endinterface

// File: rtl/core_periph_bridge.sv
// EX-stage peripheral access -> single req/ack bus transaction, d_ready pulse on completion.
// Optional bus timeout abort is enabled by defining PERIPH_TIMEOUT_EN.
module core_periph_bridge #(
    parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_d_valid,
    input  logic [63:0] i_addr,
    input  logic        i_EX_mem_read,
    input  logic        i_EX_mem_write,
    input  logic [63:0] i_wdata,
    input  logic [7:0]  i_byte_en,
    output logic        o_d_ready,
    output logic [63:0] o_rdata,
    output logic        o_d_err,
    core_periph_bridge_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic        r_we;
    logic        r_rd;
    logic [31:0] r_addr;
    logic [63:0] r_wdata;
    logic [7:0]  r_be;
    logic [63:0] r_rdata;
    logic        r_err;

    logic        w_launch;
    logic        w_ack;
    logic        w_timeout;
    logic        w_p_req;
    logic        w_d_ready;
    logic [31:0] w_offset;

    assign w_launch = (r_state == S_IDLE) && i_d_valid;
    assign w_ack    = (r_state == S_REQ) && bus.p_ack;
    assign w_offset = 32'(i_addr - PERIPHERAL_BASE);

`ifdef PERIPH_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_tmo_cnt;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_tmo_cnt <= 16'd0;
        end else if (w_launch) begin
            r_tmo_cnt <= 16'd0;
        end else if ((r_state == S_REQ) && !bus.p_ack) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    // An ack in the expiry cycle takes precedence over the abort.
    assign w_timeout = (r_state == S_REQ) && !bus.p_ack &&
                       (r_tmo_cnt == TMO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_d_valid) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.p_ack || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_p_req   = 1'b0;
        w_d_ready = 1'b0;
        unique case (r_state)
            S_REQ:   w_p_req   = 1'b1;
            S_DONE:  w_d_ready = 1'b1;
            default: begin
                w_p_req   = 1'b0;
                w_d_ready = 1'b0;
            end
        endcase
    end

    // Request fields are frozen at launch; EX inputs are ignored afterwards.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_we    <= 1'b0;
            r_rd    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 64'd0;
            r_be    <= 8'd0;
        end else if (w_launch) begin
            r_we    <= i_EX_mem_write;
            r_rd    <= i_EX_mem_read && !i_EX_mem_write;
            r_addr  <= w_offset;
            r_wdata <= i_wdata;
            r_be    <= i_EX_mem_write ? i_byte_en : 8'hFF;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rdata <= 64'd0;
            r_err   <= 1'b0;
        end else if (w_ack) begin
            r_rdata <= r_rd ? bus.p_rdata : 64'd0;
            r_err   <= bus.p_err;
        end else if (w_timeout) begin
            r_rdata <= 64'd0;
            r_err   <= 1'b1;
        end
    end

    assign bus.p_req   = w_p_req;
    assign bus.p_we    = r_we;
    assign bus.p_addr  = r_addr;
    assign bus.p_wdata = r_wdata;
    assign bus.p_be    = r_be;

    assign o_d_ready = w_d_ready;
    assign o_rdata   = r_rdata;
    assign o_d_err   = r_err;

endmodule

// File: tb/tb_core_periph_bridge.sv
// Directed self-checking bench for core_periph_bridge.
// Timeout scenario runs only when PERIPH_TIMEOUT_EN is defined.
module tb_core_periph_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_valid;
    logic [63:0] addr;
    logic        rd;
    logic        wr;
    logic [63:0] wdata;
    logic [7:0]  byte_en;
    logic        d_ready;
    logic [63:0] rdata;
    logic        d_err;

    int tests_run = 0;
    int tests_failed = 0;

    core_periph_bridge_if bus ();

    core_periph_bridge #(
        .PERIPHERAL_BASE(64'h2000_0000),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_d_valid     (d_valid),
        .i_addr        (addr),
        .i_EX_mem_read (rd),
        .i_EX_mem_write(wr),
        .i_wdata       (wdata),
        .i_byte_en     (byte_en),
        .o_d_ready     (d_ready),
        .o_rdata       (rdata),
        .o_d_err       (d_err),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle;
        d_valid       = 1'b0;
        rd            = 1'b0;
        wr            = 1'b0;
        bus.p_ack     = 1'b0;
        bus.p_err     = 1'b0;
        bus.p_rdata   = 64'd0;
    endtask

    task automatic test_reset;
        rst         = 1'b1;
        d_valid     = 1'b1;
        addr        = 64'h2000_0123;
        rd          = 1'b0;
        wr          = 1'b1;
        wdata       = 64'hABCD;
        byte_en     = 8'h5A;
        bus.p_ack   = 1'b1;
        bus.p_err   = 1'b1;
        bus.p_rdata = 64'h1234;
        step();
        step();
        tests_run++;
        if ({d_ready, d_err, rdata, bus.p_req, bus.p_we,
             bus.p_addr, bus.p_wdata, bus.p_be} !== 172'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs got rdy=%0b err=%0b rdata=%h req=%0b we=%0b addr=%h wd=%h be=%h exp all 0",
                     d_ready, d_err, rdata, bus.p_req, bus.p_we,
                     bus.p_addr, bus.p_wdata, bus.p_be);
        end
        drive_idle();
        rst = 1'b0;
        step();
        tests_run++;
        if ({bus.p_req, d_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_release_idle got req=%0b rdy=%0b exp 0 0",
                     bus.p_req, d_ready);
        end
    endtask

    task automatic test_read;
        d_valid = 1'b1;
        addr    = 64'h2000_0010;
        rd      = 1'b1;
        byte_en = 8'h03;
        step();
        tests_run++;
        if ({bus.p_req, bus.p_we, bus.p_addr, bus.p_be, d_ready} !==
            {1'b1, 1'b0, 32'h10, 8'hFF, 1'b0}) begin
            tests_failed++;
            $display("FAIL read_req got req=%0b we=%0b addr=%h be=%h rdy=%0b exp 1 0 10 ff 0",
                     bus.p_req, bus.p_we, bus.p_addr, bus.p_be, d_ready);
        end
        bus.p_ack   = 1'b1;
        bus.p_rdata = 64'hDEAD_BEEF;
        step();
        tests_run++;
        if ({d_ready, d_err, rdata, bus.p_req} !==
            {1'b1, 1'b0, 64'hDEAD_BEEF, 1'b0}) begin
            tests_failed++;
            $display("FAIL read_done got rdy=%0b err=%0b rdata=%h req=%0b exp 1 0 deadbeef 0",
                     d_ready, d_err, rdata, bus.p_req);
        end
        drive_idle();
        step();
        tests_run++;
        if ({d_ready, bus.p_req} !== 2'b00) begin
            tests_failed++;
            $display("FAIL read_after got rdy=%0b req=%0b exp 0 0",
                     d_ready, bus.p_req);
        end
    endtask

    task automatic test_slow_write;
        int bad = 0;
        d_valid = 1'b1;
        wr      = 1'b1;
        addr    = 64'h2000_0040;
        wdata   = 64'h55;
        byte_en = 8'h0F;
        for (int i = 1; i <= 5; i++) begin
            step();
            if ({bus.p_req, bus.p_we, bus.p_addr, bus.p_wdata, bus.p_be, d_ready} !==
                {1'b1, 1'b1, 32'h40, 64'h55, 8'h0F, 1'b0}) begin
                bad++;
                $display("FAIL write_hold cyc=%0d got req=%0b we=%0b addr=%h wd=%h be=%h rdy=%0b exp 1 1 40 55 0f 0",
                         i, bus.p_req, bus.p_we, bus.p_addr, bus.p_wdata, bus.p_be, d_ready);
            end
            wdata   = 64'hFFFF_0000;
            byte_en = 8'hF0;
            addr    = 64'h2000_0999;
            if (i == 2) d_valid = 1'b0;
            if (i == 5) bus.p_ack = 1'b1;
        end
        tests_run++;
        if (bad != 0) tests_failed++;
        step();
        tests_run++;
        if ({d_ready, d_err, rdata, bus.p_req} !== {1'b1, 1'b0, 64'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL write_done got rdy=%0b err=%0b rdata=%h req=%0b exp 1 0 0 0",
                     d_ready, d_err, rdata, bus.p_req);
        end
        drive_idle();
        step();
    endtask

    task automatic test_back_to_back;
        int n_req = 0;
        int n_rdy = 0;
        logic prev_req = 1'b0;
        d_valid = 1'b1;
        rd      = 1'b1;
        addr    = 64'h2000_0100;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (bus.p_req && !prev_req) n_req++;
            prev_req = bus.p_req;
            if (d_ready) n_rdy++;
            case (c)
                1: begin
                    bus.p_ack   = 1'b1;
                    bus.p_rdata = 64'hA1;
                end
                2: begin
                    tests_run++;
                    if ({d_ready, rdata} !== {1'b1, 64'hA1}) begin
                        tests_failed++;
                        $display("FAIL b2b_first got rdy=%0b rdata=%h exp 1 a1",
                                 d_ready, rdata);
                    end
                    bus.p_ack = 1'b0;
                    addr      = 64'h2000_0108;
                end
                3: begin
                    tests_run++;
                    if ({bus.p_req, d_ready} !== 2'b00) begin
                        tests_failed++;
                        $display("FAIL b2b_gap got req=%0b rdy=%0b exp 0 0",
                                 bus.p_req, d_ready);
                    end
                end
                4: begin
                    tests_run++;
                    if ({bus.p_req, bus.p_addr} !== {1'b1, 32'h108}) begin
                        tests_failed++;
                        $display("FAIL b2b_second_req got req=%0b addr=%h exp 1 108",
                                 bus.p_req, bus.p_addr);
                    end
                    bus.p_ack   = 1'b1;
                    bus.p_rdata = 64'hB2;
                end
                5: begin
                    tests_run++;
                    if ({d_ready, rdata} !== {1'b1, 64'hB2}) begin
                        tests_failed++;
                        $display("FAIL b2b_second got rdy=%0b rdata=%h exp 1 b2",
                                 d_ready, rdata);
                    end
                    drive_idle();
                end
                default: ;
            endcase
        end
        tests_run++;
        if (n_req != 2 || n_rdy != 2) begin
            tests_failed++;
            $display("FAIL b2b_counts got req=%0d rdy=%0d exp 2 2",
                     n_req, n_rdy);
        end
    endtask

`ifdef PERIPH_TIMEOUT_EN
    task automatic test_timeout;
        int bad = 0;
        d_valid = 1'b1;
        rd      = 1'b1;
        addr    = 64'h2000_0300;
        for (int i = 1; i <= 4; i++) begin
            step();
            if ({bus.p_req, d_ready} !== 2'b10) begin
                bad++;
                $display("FAIL timeout_req cyc=%0d got req=%0b rdy=%0b exp 1 0",
                         i, bus.p_req, d_ready);
            end
            if (i == 1) d_valid = 1'b0;
        end
        tests_run++;
        if (bad != 0) tests_failed++;
        step();
        tests_run++;
        if ({d_ready, d_err, rdata, bus.p_req} !== {1'b1, 1'b1, 64'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL timeout_done got rdy=%0b err=%0b rdata=%h req=%0b exp 1 1 0 0",
                     d_ready, d_err, rdata, bus.p_req);
        end
        drive_idle();
        step();
    endtask
`else
    task automatic test_no_timeout;
        int bad = 0;
        d_valid = 1'b1;
        rd      = 1'b1;
        addr    = 64'h2000_0300;
        for (int i = 1; i <= 20; i++) begin
            step();
            if ({bus.p_req, d_ready} !== 2'b10) begin
                bad++;
                $display("FAIL wait_req cyc=%0d got req=%0b rdy=%0b exp 1 0",
                         i, bus.p_req, d_ready);
            end
            if (i == 1) d_valid = 1'b0;
        end
        tests_run++;
        if (bad != 0) tests_failed++;
        bus.p_ack   = 1'b1;
        bus.p_rdata = 64'hC3;
        step();
        tests_run++;
        if ({d_ready, d_err, rdata} !== {1'b1, 1'b0, 64'hC3}) begin
            tests_failed++;
            $display("FAIL wait_done got rdy=%0b err=%0b rdata=%h exp 1 0 c3",
                     d_ready, d_err, rdata);
        end
        drive_idle();
        step();
    endtask
`endif

    task automatic test_error;
        d_valid = 1'b1;
        rd      = 1'b1;
        addr    = 64'h2000_0200;
        step();
        bus.p_ack   = 1'b1;
        bus.p_err   = 1'b1;
        bus.p_rdata = 64'h77;
        step();
        tests_run++;
        if ({d_ready, d_err} !== 2'b11) begin
            tests_failed++;
            $display("FAIL err_done got rdy=%0b err=%0b exp 1 1", d_ready, d_err);
        end
        drive_idle();
        step();
        d_valid = 1'b1;
        rd      = 1'b1;
        step();
        bus.p_ack   = 1'b1;
        bus.p_rdata = 64'h99;
        step();
        tests_run++;
        if ({d_ready, d_err, rdata} !== {1'b1, 1'b0, 64'h99}) begin
            tests_failed++;
            $display("FAIL err_clear got rdy=%0b err=%0b rdata=%h exp 1 0 99",
                     d_ready, d_err, rdata);
        end
        drive_idle();
        step();
    endtask

    task automatic test_flags_offset;
        d_valid = 1'b1;
        rd      = 1'b1;
        wr      = 1'b1;
        addr    = 64'h1_2000_0004;
        wdata   = 64'h0123_4567_89AB_CDEF;
        byte_en = 8'h3C;
        step();
        tests_run++;
        if ({bus.p_we, bus.p_addr, bus.p_be, bus.p_wdata} !==
            {1'b1, 32'h4, 8'h3C, 64'h0123_4567_89AB_CDEF}) begin
            tests_failed++;
            $display("FAIL both_flags got we=%0b addr=%h be=%h wd=%h exp 1 4 3c 0123456789abcdef",
                     bus.p_we, bus.p_addr, bus.p_be, bus.p_wdata);
        end
        bus.p_ack   = 1'b1;
        bus.p_rdata = 64'h5555;
        step();
        tests_run++;
        if ({d_ready, rdata} !== {1'b1, 64'd0}) begin
            tests_failed++;
            $display("FAIL both_flags_rdata got rdy=%0b rdata=%h exp 1 0",
                     d_ready, rdata);
        end
        drive_idle();
        step();
        d_valid = 1'b1;
        rd      = 1'b1;
        addr    = 64'h1000_0000;
        step();
        tests_run++;
        if ({bus.p_we, bus.p_addr, bus.p_be} !== {1'b0, 32'hF000_0000, 8'hFF}) begin
            tests_failed++;
            $display("FAIL below_base got we=%0b addr=%h be=%h exp 0 f0000000 ff",
                     bus.p_we, bus.p_addr, bus.p_be);
        end
        bus.p_ack = 1'b1;
        step();
        drive_idle();
        step();
    endtask

    task automatic test_ack_idle;
        int bad = 0;
        bus.p_ack   = 1'b1;
        bus.p_err   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if ({bus.p_req, d_ready} !== 2'b00) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL ack_in_idle got %0d bad cycles exp 0", bad);
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_req;
        d_valid = 1'b1;
        wr      = 1'b1;
        addr    = 64'h2000_0500;
        wdata   = 64'hFACE;
        byte_en = 8'h81;
        step();
        step();
        rst = 1'b1;
        step();
        tests_run++;
        if ({bus.p_req, d_ready, bus.p_we, bus.p_addr, bus.p_be,
             bus.p_wdata, rdata, d_err} !== 172'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_req got req=%0b rdy=%0b we=%0b addr=%h be=%h wd=%h rdata=%h err=%0b exp all 0",
                     bus.p_req, d_ready, bus.p_we, bus.p_addr, bus.p_be,
                     bus.p_wdata, rdata, d_err);
        end
        rst       = 1'b0;
        d_valid   = 1'b0;
        wr        = 1'b0;
        bus.p_ack = 1'b1;
        step();
        tests_run++;
        if ({bus.p_req, d_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL late_ack_1 got req=%0b rdy=%0b exp 0 0",
                     bus.p_req, d_ready);
        end
        step();
        tests_run++;
        if ({bus.p_req, d_ready} !== 2'b00) begin
            tests_failed++;
            $display("FAIL late_ack_2 got req=%0b rdy=%0b exp 0 0",
                     bus.p_req, d_ready);
        end
        drive_idle();
        step();
    endtask

    initial begin
        rst     = 1'b1;
        addr    = 64'd0;
        wdata   = 64'd0;
        byte_en = 8'd0;
        drive_idle();
        test_reset();
        test_read();
        test_slow_write();
        test_back_to_back();
`ifdef PERIPH_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_error();
        test_flags_offset();
        test_ack_idle();
        test_reset_mid_req();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
